uart_fifo_controller: RTL and testbench
=======================================

UART_FIFO_CONTROLLER -- requirements
Module: uart_fifo_controller

Interface
REQ-001 SHALL: clock  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL: req_a / req_b  input  1 each  requester A / requester B wants to write one byte this cycle.
REQ-004 SHALL: data_a / data_b  input  8 each  byte offered by requester A / requester B.
REQ-005 SHALL: grant_a / grant_b  output  1 each  requester's byte is accepted this cycle (combinational, one-hot or zero).
REQ-006 SHALL: fifo_write_flag  output  1  write strobe to the FIFO.
REQ-007 SHALL: fifo_data_in  output  8  byte written to the FIFO.
REQ-008 SHALL: fifo_full_flag / fifo_empty_flag  input  1 each  FIFO status, combinational from FIFO occupancy.
REQ-009 SHALL: fifo_data_out  input  8  FIFO head byte, registered in the FIFO (one-cycle lag behind pointer/content changes).
REQ-010 SHALL: fifo_read_next  output  1  pop strobe to the FIFO.
REQ-011 SHALL: tx_ready  input  1  UART transmitter idle and able to accept a byte.
REQ-012 SHALL: tx_start  output  1  one-cycle pulse; tx_data is valid.
REQ-013 SHALL: tx_data  output  8  byte to transmit, held stable from the tx_start cycle until the next tx_start.
REQ-014 SHALL: tx_done  input  1  one-cycle pulse at end of the UART frame.
REQ-015 SHALL: busy  output  1  high in every sequencer state except IDLE.

Function
REQ-016 SHALL: Write arbitration is round-robin with a 1-bit last_grant register; on contention, grant goes to the requester not granted last.
REQ-017 SHALL: With one requester active, that requester is granted regardless of last_grant.
REQ-018 SHALL: No grant is issued while fifo_full_flag=1, so the FIFO never overwrites its oldest byte.
REQ-019 SHALL: fifo_write_flag = grant_a|grant_b.
REQ-020 SHALL: fifo_data_in = data of the granted requester, and 0 when there is no grant.
REQ-021 SHALL: last_grant updates only on a cycle with a grant.
REQ-022 SHALL: Read sequencer states: IDLE, FETCH, SEND, WAIT_TX, SETTLE.
REQ-023 SHALL: IDLE->FETCH when fifo_empty_flag=0 and tx_ready=1.
REQ-024 SHALL: FETCH->SEND unconditionally, absorbing the fifo_data_out register lag.
REQ-025 SHALL: In SEND, for exactly one cycle: tx_data<=fifo_data_out, tx_start=1 and fifo_read_next=1; then ->WAIT_TX.
REQ-026 SHALL: WAIT_TX->SETTLE on tx_done.
REQ-027 SHALL: SETTLE->IDLE unconditionally, allowing the post-pop fifo_data_out update.
REQ-028 SHALL: Throughput is at most one byte per (4 + UART frame) cycles; minimum latency from non-empty to tx_start is 2 cycles.
REQ-029 SHALL: A write and a pop in the same cycle are legal; the controller takes no special action.
REQ-030 SHALL: fifo_read_next is never asserted outside SEND, so the FIFO is never popped while empty.
REQ-031 SHALL: A tx_done received outside WAIT_TX is ignored.
REQ-032 SHALL: tx_ready is sampled only in IDLE.

Reset
REQ-033 SHALL: On reset assertion, the state goes immediately to IDLE, last_grant=B (so A wins the first contention), tx_data=0, and tx_start, fifo_read_next, busy are all 0.
REQ-034 SHALL: A reset mid-frame abandons the byte; the FIFO is reset by the same reset line, so no pop is owed.

Structure
REQ-035 SHALL: A shared package holds the state encoding localparams (3-bit) and DATA_WIDTH=8.
REQ-036 SHALL: One sub-module, uart_fifo_rr_arbiter, implements REQ-016..REQ-021; the sequencer lives in the top module.

Verification
REQ-037 SHALL: Reset, then req_a=req_b=1 with data_a=0x11, data_b=0x22 for 4 cycles -> FIFO receives 0x11, 0x22, 0x11, 0x22.
REQ-038 SHALL: fifo_full_flag=1 with req_a=1 -> grant_a=0 and fifo_write_flag=0 on every cycle while full.
REQ-039 SHALL: Write 0xA5 into an empty FIFO with tx_ready=1 -> tx_start pulses 2 cycles after empty deasserts, with tx_data=0xA5 and one fifo_read_next.
REQ-040 SHALL: Queue 0x01, 0x02, 0x03 with tx_done 10 cycles after each tx_start -> transmitted in order, exactly 3 pops, busy low at end.
REQ-041 SHALL: Assert reset during WAIT_TX -> state IDLE and busy=0 immediately; no tx_start until new data arrives.
REQ-042 SHALL: Stray tx_done pulse while IDLE with the FIFO empty -> no state change and no pop.

Source files
------------

// File: rtl/uart_fifo_controller_pkg.sv
// uart_fifo_controller_pkg: shared data width and read-sequencer state encoding
package uart_fifo_controller_pkg;
   localparam int DATA_WIDTH = 8;
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_FETCH   = 3'd1;
   localparam logic [2:0] ST_SEND    = 3'd2;
   localparam logic [2:0] ST_WAIT_TX = 3'd3;
   localparam logic [2:0] ST_SETTLE  = 3'd4;
   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      FETCH   = ST_FETCH,
      SEND    = ST_SEND,
      WAIT_TX = ST_WAIT_TX,
      SETTLE  = ST_SETTLE
   } state_e;
endpackage

// File: rtl/uart_fifo_rr_arbiter.sv
// uart_fifo_rr_arbiter: two-requester round-robin write arbiter in front of the FIFO.
//   req_a_i/req_b_i, data_a_i/data_b_i : requests and offered bytes
//   full_i                             : FIFO full, blocks all grants
//   grant_a_o/grant_b_o                : one-hot (or zero) grants
//   write_o, data_o                    : FIFO write strobe and byte (0 when idle)
module uart_fifo_rr_arbiter
   import uart_fifo_controller_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_a_i,
   input  logic                  req_b_i,
   input  logic [DATA_WIDTH-1:0] data_a_i,
   input  logic [DATA_WIDTH-1:0] data_b_i,
   input  logic                  full_i,
   output logic                  grant_a_o,
   output logic                  grant_b_o,
   output logic                  write_o,
   output logic [DATA_WIDTH-1:0] data_o
);
   // last_b_q=1 means B was granted last; reset value lets A win the first contention
   logic last_b_q, last_b_d;
   always_comb begin
      grant_a_o = !full_i && req_a_i && (!req_b_i || last_b_q);
      grant_b_o = !full_i && req_b_i && (!req_a_i || !last_b_q);
      write_o   = grant_a_o || grant_b_o;
      data_o    = grant_a_o ? data_a_i : grant_b_o ? data_b_i : '0;
      last_b_d  = grant_a_o ? 1'b0 : grant_b_o ? 1'b1 : last_b_q;
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) last_b_q <= 1'b1;
      else       last_b_q <= last_b_d;
endmodule

// File: rtl/uart_fifo_controller.sv
// uart_fifo_controller: arbitrates two byte writers into a FIFO and drains it to a UART.
//   req_*/data_*/grant_*          : writer side
//   fifo_*                        : FIFO write/pop strobes, data and status
//   tx_ready_i/tx_start_o/tx_data_o/tx_done_i : UART transmitter handshake
//   busy_o                        : read sequencer not idle
module uart_fifo_controller
   import uart_fifo_controller_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_a_i,
   input  logic                  req_b_i,
   input  logic [DATA_WIDTH-1:0] data_a_i,
   input  logic [DATA_WIDTH-1:0] data_b_i,
   output logic                  grant_a_o,
   output logic                  grant_b_o,
   output logic                  fifo_write_flag_o,
   output logic [DATA_WIDTH-1:0] fifo_data_in_o,
   input  logic                  fifo_full_flag_i,
   input  logic                  fifo_empty_flag_i,
   input  logic [DATA_WIDTH-1:0] fifo_data_out_i,
   output logic                  fifo_read_next_o,
   input  logic                  tx_ready_i,
   output logic                  tx_start_o,
   output logic [DATA_WIDTH-1:0] tx_data_o,
   input  logic                  tx_done_i,
   output logic                  busy_o
);
   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  send;
   uart_fifo_rr_arbiter u_arb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_a_i  (req_a_i),
      .req_b_i  (req_b_i),
      .data_a_i (data_a_i),
      .data_b_i (data_b_i),
      .full_i   (fifo_full_flag_i),
      .grant_a_o(grant_a_o),
      .grant_b_o(grant_b_o),
      .write_o  (fifo_write_flag_o),
      .data_o   (fifo_data_in_o)
   );
   // FETCH absorbs the FIFO output register lag; SETTLE lets the post-pop head update land
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!fifo_empty_flag_i && tx_ready_i) state_d = FETCH;
         FETCH:   state_d = SEND;
         SEND:    state_d = WAIT_TX;
         WAIT_TX: if (tx_done_i) state_d = SETTLE;
         SETTLE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // Head byte is passed through during SEND so tx_data is already valid with tx_start
   always_comb begin
      send             = state_q == SEND;
      tx_data_d        = send ? fifo_data_out_i : tx_data_q;
      tx_data_o        = tx_data_d;
      tx_start_o       = send;
      fifo_read_next_o = send;
      busy_o           = state_q != IDLE;
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state_q   <= IDLE;
         tx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         tx_data_q <= tx_data_d;
      end
endmodule

// File: tb/tb_uart_fifo_controller.sv
// tb_uart_fifo_controller: scoreboard bench with a behavioural FIFO and UART responder
module tb_uart_fifo_controller;
   logic       clk = 0, rst = 1;
   logic       req_a = 0, req_b = 0, tx_ready = 0, tx_done = 0, force_full = 0, auto_done = 0;
   logic [7:0] data_a = 0, data_b = 0;
   logic       grant_a, grant_b, wr, rd, tx_start, busy, full, empty;
   logic [7:0] din, dout, tx_data;
   logic [7:0] mem [16];
   logic [4:0] cnt;
   logic [3:0] wp, rp;
   int         compared = 0, mismatched = 0, pops = 0, starts = 0;
   logic [7:0] wq[$], tq[$];

   always #5 clk = ~clk;

   uart_fifo_controller dut (
      .clk_i(clk), .rst_i(rst), .req_a_i(req_a), .req_b_i(req_b),
      .data_a_i(data_a), .data_b_i(data_b), .grant_a_o(grant_a), .grant_b_o(grant_b),
      .fifo_write_flag_o(wr), .fifo_data_in_o(din), .fifo_full_flag_i(full),
      .fifo_empty_flag_i(empty), .fifo_data_out_i(dout), .fifo_read_next_o(rd),
      .tx_ready_i(tx_ready), .tx_start_o(tx_start), .tx_data_o(tx_data),
      .tx_done_i(tx_done), .busy_o(busy)
   );

   // FIFO model: status combinational from occupancy, head byte registered one cycle late
   assign full  = force_full || cnt == 5'd16;
   assign empty = cnt == 5'd0;
   always @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= 0; wp <= 0; rp <= 0; dout <= 0;
      end else begin
         if (wr) begin mem[wp] <= din; wp <= wp + 4'd1; end
         if (rd) rp <= rp + 4'd1;
         cnt  <= cnt + 5'(wr) - 5'(rd);
         dout <= mem[rp];
      end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expected bytes whenever the DUT writes the FIFO or starts a transmit
   always @(negedge clk) if (!rst) begin
      if (wr) begin
         chk("wr_onehot", 32'($countones({grant_a, grant_b})), 1);
         if (wq.size() == 0) chk("wr_unexpected", {24'd0, din}, 32'hFFFF_FFFF);
         else chk("wr_data", {24'd0, din}, {24'd0, wq.pop_front()});
      end
      if (rd || tx_start) chk("pop_with_start", {31'd0, rd}, {31'd0, tx_start});
      if (rd) pops++;
      if (tx_start) begin
         starts++;
         if (tq.size() == 0) chk("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
         else chk("tx_data", {24'd0, tx_data}, {24'd0, tq.pop_front()});
      end
   end

   // UART responder: tx_done pulse 10 cycles after each tx_start
   initial forever begin
      @(negedge clk);
      if (auto_done && tx_start && !rst) begin
         repeat (10) @(posedge clk);
         #1 tx_done = 1;
         @(posedge clk);
         #1 tx_done = 0;
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      #1 rst = 1;
      step();
      rst = 0;
      step();
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while ((busy || !empty) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, {31'd0, n < budget}, 1);
   endtask

   initial begin
      int p0, s0;
      #12;
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_tx_start", {31'd0, tx_start}, 0);
      chk("rst_read_next", {31'd0, rd}, 0);
      chk("rst_tx_data", {24'd0, tx_data}, 0);
      rst = 0;
      step();
      // Contention: A first after reset, then alternating
      req_a = 1; req_b = 1; data_a = 8'h11; data_b = 8'h22;
      for (int i = 0; i < 4; i++) begin
         wq.push_back(i % 2 == 0 ? 8'h11 : 8'h22);
         @(negedge clk);
         chk("rr_grant_a", {31'd0, grant_a}, {31'd0, i % 2 == 0});
         step();
      end
      req_b = 0;
      // Full FIFO blocks every grant
      force_full = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("full_grant_a", {31'd0, grant_a}, 0);
         chk("full_write", {31'd0, wr}, 0);
         step();
      end
      req_a = 0; force_full = 0;
      chk("rr_wq_drained", wq.size(), 0);
      do_reset();
      // Single byte: tx_start 2 cycles after empty deasserts
      tx_ready = 1; auto_done = 1;
      p0 = pops;
      req_a = 1; data_a = 8'hA5;
      wq.push_back(8'hA5); tq.push_back(8'hA5);
      step();
      req_a = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("latency_tx_start", {31'd0, tx_start}, {31'd0, i == 2});
      end
      wait_idle("a5_timeout", 100);
      chk("a5_pops", pops - p0, 1);
      // Three queued bytes transmitted in order
      p0 = pops;
      req_b = 1;
      for (int i = 1; i <= 3; i++) begin
         data_b = 8'(i);
         wq.push_back(8'(i)); tq.push_back(8'(i));
         step();
      end
      req_b = 0;
      wait_idle("seq3_timeout", 200);
      chk("seq3_pops", pops - p0, 3);
      chk("seq3_busy", {31'd0, busy}, 0);
      // Reset during WAIT_TX
      auto_done = 0;
      req_a = 1; data_a = 8'h5A;
      wq.push_back(8'h5A); tq.push_back(8'h5A);
      step();
      req_a = 0;
      begin
         int n = 0;
         while (!tx_start && n < 20) begin @(negedge clk); n++; end
         chk("wait_start_timeout", {31'd0, n < 20}, 1);
      end
      step(); step();
      #1 rst = 1;
      #1;
      chk("midrst_busy", {31'd0, busy}, 0);
      chk("midrst_tx_start", {31'd0, tx_start}, 0);
      chk("midrst_tx_data", {24'd0, tx_data}, 0);
      step();
      rst = 0;
      s0 = starts;
      repeat (10) @(negedge clk);
      chk("midrst_no_start", starts - s0, 0);
      auto_done = 1;
      req_b = 1; data_b = 8'h77;
      wq.push_back(8'h77); tq.push_back(8'h77);
      step();
      req_b = 0;
      wait_idle("post_rst_timeout", 100);
      chk("post_rst_start", starts - s0, 1);
      // Stray tx_done while idle and empty
      auto_done = 0;
      p0 = pops;
      tx_done = 1;
      step();
      tx_done = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stray_busy", {31'd0, busy}, 0);
      end
      chk("stray_pops", pops - p0, 0);
      chk("end_wq_empty", wq.size(), 0);
      chk("end_tq_empty", tq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
